// File: rtl/op_request_master.sv
// op_request_master
//   Initiator side of the start/a/b -> y/valid compute-unit interface.
//   Takes one operand pair from a valid/ready input stream, issues a one-cycle
//   start pulse with a/b held stable, waits for the unit's valid pulse (or a
//   timeout), and presents the captured result on a valid/ready output stream.
//   Only one transaction is outstanding at a time.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand stream handshake (in_ready high only in IDLE)
//   in_a, in_b          operands
//   start               one-cycle request pulse to the unit
//   a, b                operands to the unit, stable from accept to next accept
//   y, valid            result and result-valid pulse from the unit
//   out_valid/out_ready result stream handshake
//   out_y, out_err      captured result (0 on timeout), timeout flag
//   stray               one-cycle pulse when valid arrives in IDLE or HOLD
//   txn_cnt             count of handed-off transactions, wraps
module op_request_master #(
  parameter int unsigned W       = 10,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y,
  input  logic             valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic             out_err,
  output logic             stray,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    timer_q;
  logic             start_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             out_valid_q;
  logic [W-1:0]     out_y_q;
  logic             out_err_q;
  logic             stray_q;
  logic [CNT_W-1:0] txn_cnt_q;

  assign in_ready  = (state_q == IDLE);
  assign start     = start_q;
  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;
  assign stray     = stray_q;
  assign txn_cnt   = txn_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
      stray_q     <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      // A unit response is only meaningful while a request is in flight.
      stray_q <= valid && ((state_q == IDLE) || (state_q == HOLD));

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end

        ISSUE: begin
          start_q <= 1'b0;
          timer_q <= '0;
          // Early response in the start cycle is accepted like a WAIT hit.
          if (valid) begin
            out_y_q     <= y;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          timer_q <= timer_q + 1'b1;
          // valid is tested first so it wins over a coincident timeout.
          if (valid) begin
            out_y_q     <= y;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            out_y_q     <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            txn_cnt_q   <= txn_cnt_q + 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_request_master.sv
module tb_op_request_master;

  localparam int W       = 10;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     y = '0;
  logic             valid = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_y;
  logic             out_err;
  logic             stray;
  logic [CNT_W-1:0] txn_cnt;

  always #5 clk = ~clk;

  op_request_master #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .a(a), .b(b), .y(y), .valid(valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .stray(stray), .txn_cnt(txn_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is "active" from accept until the
  // result handshake; m_age counts cycles since accept (1 = start cycle).
  bit               m_active = 0;
  bit               m_done   = 0;
  bit               m_err    = 0;
  bit               m_stray  = 0;
  int               m_age    = 0;
  logic [W-1:0]     m_a = '0, m_b = '0, m_y = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_err = 0; m_stray = 0; m_age = 0;
      m_a = '0; m_b = '0; m_y = '0; m_cnt = '0;
    end else begin
      bit st;
      st = valid && (!m_active || m_done);
      if (!m_active) begin
        if (in_valid) begin
          m_active = 1; m_done = 0; m_age = 1; m_a = in_a; m_b = in_b;
        end
      end else if (!m_done) begin
        if (valid) begin
          m_done = 1; m_y = y; m_err = 0;
        end else if (m_age == TIMEOUT + 1) begin
          m_done = 1; m_y = '0; m_err = 1;
        end else begin
          m_age++;
        end
      end else if (out_ready) begin
        m_active = 0;
        m_cnt++;
      end
      m_stray = st;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_active);
    chk("start", start, m_active && !m_done && m_age == 1);
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("out_valid", out_valid, m_active && m_done);
    if (m_active && m_done) begin
      chk("out_y", out_y, m_y);
      chk("out_err", out_err, m_err);
    end
    chk("stray", stray, m_stray);
    chk("txn_cnt", txn_cnt, m_cnt);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // dly: cycles after the start cycle at which the unit pulses valid (<0: never).
  task automatic do_txn(input logic [W-1:0] ia, input logic [W-1:0] ib, input int dly,
                        input logic [W-1:0] ry, input int bp,
                        output logic [W-1:0] got_y, output logic got_err,
                        output int lat, output int starts);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    if (!in_ready) chk("in_ready_wait_expired", 0, 1);
    in_valid = 1; in_a = ia; in_b = ib;
    tick;
    in_valid = 0;
    starts = int'(start);
    in_a = ~ia; in_b = ~ib;
    lat = 0;
    for (int i = 0; i < TIMEOUT + 8 && !out_valid; i++) begin
      if (i == dly) begin valid = 1; y = ry; end
      tick;
      valid = 0; y = '0;
      lat++;
      starts += int'(start);
      if (i == 0) begin
        chk("a_stable", a, ia);
        chk("b_stable", b, ib);
      end
    end
    if (!out_valid) chk("out_valid_wait_expired", 0, 1);
    got_y = out_y; got_err = out_err;
    repeat (bp) begin
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_y", out_y, got_y);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  logic [W-1:0] gy;
  logic         ge;
  int           lat, st;

  initial begin
    repeat (3) tick;
    rst_n = 1;
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // T1 basic
    do_txn(10'd5, 10'd7, 2, 10'd12, 0, gy, ge, lat, st);
    chk("t1_y", gy, 10'd12);
    chk("t1_err", ge, 0);
    chk("t1_latency", lat, 3);
    chk("t1_starts", st, 1);
    chk("t1_cnt", txn_cnt, 1);

    // T2 backpressure
    do_txn(10'd9, 10'd3, 3, 10'h155, 5, gy, ge, lat, st);
    chk("t2_y", gy, 10'h155);
    chk("t2_cnt", txn_cnt, 2);

    // T3 timeout
    do_txn(10'd1, 10'd2, -1, 10'h2AA, 0, gy, ge, lat, st);
    chk("t3_y", gy, 0);
    chk("t3_err", ge, 1);
    chk("t3_latency", lat, 17);
    chk("t3_cnt", txn_cnt, 3);

    // T4 valid coincides with last timeout cycle
    do_txn(10'd4, 10'd4, 16, 10'h3FF, 0, gy, ge, lat, st);
    chk("t4_y", gy, 10'h3FF);
    chk("t4_err", ge, 0);
    chk("t4_latency", lat, 17);

    // T5 stray valid in IDLE
    valid = 1; y = 10'd123;
    tick;
    valid = 0; y = '0;
    chk("t5_stray", stray, 1);
    chk("t5_no_out_valid", out_valid, 0);
    tick;
    chk("t5_stray_clear", stray, 0);

    // T6 reset in WAIT
    in_valid = 1; in_a = 10'd77; in_b = 10'd88;
    tick;
    in_valid = 0;
    repeat (4) tick;
    rst_n = 0;
    #2;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_start", start, 0);
    chk("t6_a", a, 0);
    chk("t6_b", b, 0);
    chk("t6_cnt", txn_cnt, 0);
    chk("t6_in_ready", in_ready, 1);
    tick; tick;
    rst_n = 1;
    tick;

    // T6 wrap
    for (int i = 0; i < 256; i++) begin
      do_txn(W'(i), W'(255 - i), 1, W'(i + 3), 0, gy, ge, lat, st);
      if (i == 100) chk("t6_mid_cnt", txn_cnt, 101);
    end
    chk("t6_wrap_cnt", txn_cnt, 0);

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
